// File: rtl/led_blink_arbiter_if.sv
// led_blink_arbiter_if
//   Groups the request/pattern/grant signals of the LED blink arbiter.
//   Suffixes are from the arbiter's point of view: _i into the arbiter,
//   _o out of it.
//   req_i      [1:0]        request level per requester
//   on_len_i   [2*CNT_W-1:0] LED-on length, slice i = requester i
//   off_len_i  [2*CNT_W-1:0] LED-off length, slice i = requester i
//   blinks_i   [2*BLK_W-1:0] blink count, slice i = requester i
//   gnt_o      [1:0]        one-hot grant
//   done_o     [1:0]        one-cycle completion pulse
//   busy_o                  sequence in progress
//   led_o                   LED drive
interface led_blink_arbiter_if #(
  parameter int CNT_W = 16,
  parameter int BLK_W = 8
) ();
  logic [1:0]         req_i;
  logic [2*CNT_W-1:0] on_len_i;
  logic [2*CNT_W-1:0] off_len_i;
  logic [2*BLK_W-1:0] blinks_i;
  logic [1:0]         gnt_o;
  logic [1:0]         done_o;
  logic               busy_o;
  logic               led_o;

  modport master (
    output req_i, on_len_i, off_len_i, blinks_i,
    input  gnt_o, done_o, busy_o, led_o
  );

  modport slave (
    input  req_i, on_len_i, off_len_i, blinks_i,
    output gnt_o, done_o, busy_o, led_o
  );
endinterface

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter
//   Round-robin arbiter between two requesters sharing one LED. The winner's
//   on/off/blink pattern is latched at grant and played out; done pulses one
//   cycle after the last OFF phase, and dropping the request mid-sequence aborts.
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    led_blink_arbiter_if slave modport (req/pattern in, gnt/done/busy/led out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no LED activity; may hold a zero-blink grant for one cycle
//   ON    | LED high, phase counter counting down the on length
//   OFF   | LED low, phase counter counting down the off length
module led_blink_arbiter #(
  parameter int CNT_W = 16,
  parameter int BLK_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  led_blink_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BLK_W-1:0] BLK_ONE = {{(BLK_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic [1:0]         done_q, done_d;
  logic               led_q, led_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]   on_ld_q, on_ld_d;
  logic [CNT_W-1:0]   off_ld_q, off_ld_d;

  logic               sel;
  logic               gidx;
  logic [CNT_W-1:0]   sel_on;
  logic [CNT_W-1:0]   sel_off;
  logic [BLK_W-1:0]   sel_blk;

  // Phase length L is loaded as L-1 so the counter ends at zero; 0 acts as 1.
  function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : (len - CNT_ONE);
  endfunction

  // Pointer only matters when both request; a lone requester always wins.
  assign sel     = (bus.req_i == 2'b11) ? prio_q : bus.req_i[1];
  assign gidx    = gnt_q[1];
  assign sel_on  = sel ? bus.on_len_i[2*CNT_W-1:CNT_W]  : bus.on_len_i[CNT_W-1:0];
  assign sel_off = sel ? bus.off_len_i[2*CNT_W-1:CNT_W] : bus.off_len_i[CNT_W-1:0];
  assign sel_blk = sel ? bus.blinks_i[2*BLK_W-1:BLK_W]  : bus.blinks_i[BLK_W-1:0];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = 2'b00;
    led_d     = 1'b0;
    prio_d    = prio_q;
    ph_cnt_d  = ph_cnt_q;
    blk_cnt_d = blk_cnt_q;
    on_ld_d   = on_ld_q;
    off_ld_d  = off_ld_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_q != 2'b00) begin
          // Zero-blink grant: complete on the edge after the grant.
          gnt_d  = 2'b00;
          done_d = gnt_q;
          prio_d = ~gidx;
        end else if (bus.req_i != 2'b00) begin
          gnt_d    = sel ? 2'b10 : 2'b01;
          on_ld_d  = len_to_load(sel_on);
          off_ld_d = len_to_load(sel_off);
          if (sel_blk != '0) begin
            state_d   = ST_ON;
            led_d     = 1'b1;
            ph_cnt_d  = len_to_load(sel_on);
            blk_cnt_d = sel_blk - BLK_ONE;
          end
        end
      end

      ST_ON: begin
        if (!bus.req_i[gidx]) begin
          state_d   = ST_IDLE;
          gnt_d     = 2'b00;
          prio_d    = ~gidx;
          ph_cnt_d  = '0;
          blk_cnt_d = '0;
        end else if (ph_cnt_q == '0) begin
          state_d  = ST_OFF;
          ph_cnt_d = off_ld_q;
        end else begin
          led_d    = 1'b1;
          ph_cnt_d = ph_cnt_q - CNT_ONE;
        end
      end

      ST_OFF: begin
        if (!bus.req_i[gidx]) begin
          state_d   = ST_IDLE;
          gnt_d     = 2'b00;
          prio_d    = ~gidx;
          ph_cnt_d  = '0;
          blk_cnt_d = '0;
        end else if (ph_cnt_q == '0) begin
          if (blk_cnt_q == '0) begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
            done_d  = gnt_q;
            prio_d  = ~gidx;
          end else begin
            state_d   = ST_ON;
            led_d     = 1'b1;
            ph_cnt_d  = on_ld_q;
            blk_cnt_d = blk_cnt_q - BLK_ONE;
          end
        end else begin
          ph_cnt_d = ph_cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      led_q     <= 1'b0;
      prio_q    <= 1'b0;
      ph_cnt_q  <= '0;
      blk_cnt_q <= '0;
      on_ld_q   <= '0;
      off_ld_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      led_q     <= led_d;
      prio_q    <= prio_d;
      ph_cnt_q  <= ph_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      on_ld_q   <= on_ld_d;
      off_ld_q  <= off_ld_d;
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.done_o = done_q;
  assign bus.led_o  = led_q;
  assign bus.busy_o = (state_q == ST_ON) || (state_q == ST_OFF);

endmodule

// File: tb/tb_led_blink_arbiter.sv
module tb_led_blink_arbiter;
  localparam int CNT_W = 16;
  localparam int BLK_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_blink_arbiter_if #(.CNT_W(CNT_W), .BLK_W(BLK_W)) bus ();

  led_blink_arbiter #(.CNT_W(CNT_W), .BLK_W(BLK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] done;
    logic       led;
    logic       busy;
  } exp_t;

  exp_t plan[$];
  exp_t cur;
  int   m_prio;
  int   m_owner;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("gnt",  {30'd0, bus.gnt_o},  {30'd0, cur.gnt});
    check_val("done", {30'd0, bus.done_o}, {30'd0, cur.done});
    check_val("led",  {31'd0, bus.led_o},  {31'd0, cur.led});
    check_val("busy", {31'd0, bus.busy_o}, {31'd0, cur.busy});
  endtask

  function automatic int field_cnt(input logic [2*CNT_W-1:0] v, input int i);
    return int'(v[i*CNT_W +: CNT_W]);
  endfunction

  function automatic int field_blk(input logic [2*BLK_W-1:0] v, input int i);
    return int'(v[i*BLK_W +: BLK_W]);
  endfunction

  // Whole-transaction reference: on grant, the full cycle-by-cycle
  // outcome of the sequence is queued; each edge pops one entry unless
  // the owner's request was low during a busy cycle.
  task automatic model_edge();
    logic [1:0] r;
    logic [1:0] g;
    int i, on_n, off_n, nb;
    r = bus.req_i;
    if (cur.busy && !r[m_owner]) begin
      plan.delete();
      cur = '0;
      m_prio = 1 - m_owner;
    end else if (plan.size() > 0) begin
      cur = plan.pop_front();
      if (cur.done != 2'b00) m_prio = 1 - m_owner;
    end else if (r != 2'b00) begin
      i = (r == 2'b11) ? m_prio : (r[1] ? 1 : 0);
      m_owner = i;
      g = (i == 1) ? 2'b10 : 2'b01;
      on_n  = field_cnt(bus.on_len_i, i);
      off_n = field_cnt(bus.off_len_i, i);
      nb    = field_blk(bus.blinks_i, i);
      if (on_n == 0) on_n = 1;
      if (off_n == 0) off_n = 1;
      if (nb == 0) begin
        plan.push_back('{g, 2'b00, 1'b0, 1'b0});
      end else begin
        for (int b = 0; b < nb; b++) begin
          for (int k = 0; k < on_n; k++)  plan.push_back('{g, 2'b00, 1'b1, 1'b1});
          for (int k = 0; k < off_n; k++) plan.push_back('{g, 2'b00, 1'b0, 1'b1});
        end
      end
      plan.push_back('{2'b00, g, 1'b0, 1'b0});
      cur = plan.pop_front();
    end else begin
      cur = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic model_reset();
    plan.delete();
    cur = '0;
    m_prio = 0;
  endtask

  // Called just after a checked edge; asserts reset between edges.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("async_led",  {31'd0, bus.led_o},  32'd0);
    check_val("async_done", {30'd0, bus.done_o}, 32'd0);
    check_val("async_gnt",  {30'd0, bus.gnt_o},  32'd0);
    check_val("async_busy", {31'd0, bus.busy_o}, 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b0;
  endtask

  task automatic set_pattern(input int i, input int on_l, input int off_l, input int nb);
    bus.on_len_i[i*CNT_W +: CNT_W]  = CNT_W'(on_l);
    bus.off_len_i[i*CNT_W +: CNT_W] = CNT_W'(off_l);
    bus.blinks_i[i*BLK_W +: BLK_W]  = BLK_W'(nb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.req_i = 2'b11;
    bus.on_len_i = '0;
    bus.off_len_i = '0;
    bus.blinks_i = '0;
    set_pattern(0, 1, 1, 1);
    set_pattern(1, 1, 1, 1);
    model_reset();

    // Reset held with both requests high: everything stays quiet.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check_outputs();
    end

    // Single requester, two blinks of on=2 off=3.
    bus.req_i = 2'b01;
    set_pattern(0, 2, 3, 2);
    reset = 1'b0;
    steps(14);

    // Both requesting: alternation 0,1,0,1.
    async_reset();
    bus.req_i = 2'b11;
    set_pattern(0, 1, 1, 1);
    set_pattern(1, 1, 1, 1);
    steps(13);

    // Abort in the second ON cycle, pending requester 1 takes over.
    async_reset();
    set_pattern(0, 5, 1, 1);
    set_pattern(1, 2, 2, 1);
    bus.req_i = 2'b11;
    step();
    step();
    bus.req_i = 2'b10;
    steps(8);

    // Zero blinks, then zero lengths treated as one.
    async_reset();
    bus.req_i = 2'b01;
    set_pattern(0, 3, 3, 0);
    steps(3);
    set_pattern(0, 0, 0, 3);
    steps(9);

    // Reset arrives mid-ON; sequence restarts from IDLE afterwards.
    async_reset();
    set_pattern(0, 5, 2, 2);
    guard = 0;
    while (!cur.led && guard < 20) begin
      step();
      guard++;
    end
    check_val("reached_on", {31'd0, cur.led}, 32'd1);
    step();
    async_reset();
    steps(20);

    // Randomized traffic with occasional pattern changes, drops and resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) bus.req_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        set_pattern(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 599) == 0) async_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
